// File: rtl/vx_tlb_miss_arb.sv
// ---------------------------------------------------------------------------
// vx_tlb_miss_arb
//
// Shares one page-table walker among the TLB banks of a single TLB. Pending
// misses are granted round-robin, one walk is in flight at a time, and the
// walk result goes back to the missing bank as an update (or as a one-cycle
// page-fault pulse). After its update/fault completes, a bank is held off for
// HOLDOFF cycles so the bank's own update-write latency cannot trigger a
// redundant re-walk of the same VPN.
//
// Optional feature macro: VX_TLB_ARB_PERF_EN adds saturating perf counters.
//
// Ports:
//   clk, reset           clock, asynchronous active-high reset
//   miss_valid/vpn/ready per-bank miss requests, one-hot combinational grant
//   ptw_req_*            walk request to the PTW (valid/ready)
//   ptw_rsp_*            walk result from the PTW (valid/ready, ppn, fault)
//   upd_valid/vpn/ppn    one-hot update strobe with shared data, upd_ready in
//   fault_valid/vpn/bank single-cycle page-fault report
//   perf_walks/stalls    (VX_TLB_ARB_PERF_EN only) walk and stall counters
// ---------------------------------------------------------------------------
`ifndef XLEN
`define XLEN 32
`endif

module vx_tlb_miss_arb #(
  parameter int NUM_BANKS = 4,
  parameter int VPN_WIDTH = `XLEN - 12,
  parameter int HOLDOFF   = 2,
  localparam int BANK_W   = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_BANKS-1:0]           miss_valid,
  input  logic [NUM_BANKS*VPN_WIDTH-1:0] miss_vpn,
  output logic [NUM_BANKS-1:0]           miss_ready,
  output logic                           ptw_req_valid,
  output logic [VPN_WIDTH-1:0]           ptw_req_vpn,
  input  logic                           ptw_req_ready,
  input  logic                           ptw_rsp_valid,
  input  logic [VPN_WIDTH-1:0]           ptw_rsp_ppn,
  input  logic                           ptw_rsp_fault,
  output logic                           ptw_rsp_ready,
  output logic [NUM_BANKS-1:0]           upd_valid,
  output logic [VPN_WIDTH-1:0]           upd_vpn,
  output logic [VPN_WIDTH-1:0]           upd_ppn,
  input  logic [NUM_BANKS-1:0]           upd_ready,
  output logic                           fault_valid,
  output logic [VPN_WIDTH-1:0]           fault_vpn,
  output logic [BANK_W-1:0]              fault_bank
`ifdef VX_TLB_ARB_PERF_EN
  ,
  output logic [31:0]                    perf_walks,
  output logic [31:0]                    perf_stalls
`endif
);

  localparam int HOLD_W = $clog2(HOLDOFF + 1);
  localparam int CNT_W  = BANK_W + 1;
  localparam logic [NUM_BANKS-1:0] BANK_ONE  = NUM_BANKS'(1);
  localparam logic [CNT_W-1:0]     BANK_CNT  = CNT_W'(NUM_BANKS);
  localparam logic [HOLD_W-1:0]    HOLD_LOAD = HOLD_W'(HOLDOFF);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    RSP  = 3'd2,
    UPD  = 3'd3,
    FLT  = 3'd4
  } state_t;

  state_t                 state_r, state_next_s;
  logic [BANK_W-1:0]      rr_ptr_r, bank_r, winner_s, rr_next_s, bank_next_s;
  logic [VPN_WIDTH-1:0]   vpn_r, ppn_r, winner_vpn_s;
  logic [HOLD_W-1:0]      holdoff_r [NUM_BANKS];
  logic [NUM_BANKS-1:0]   hold_active_s, eligible_s, miss_ready_s, upd_valid_r;
  logic [CNT_W-1:0]       cand_s, inc_s;
  logic                   found_s, hit_s, fire_s;
  logic                   req_fire_s, rsp_fire_s, upd_fire_s, done_s;
  logic                   req_valid_r, rsp_ready_r, fault_valid_r;

  // Eligibility: a live miss from a bank that is not in its holdoff window.
  always_comb begin
    hold_active_s = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      hold_active_s[b] = (holdoff_r[b] != '0);
    end
    eligible_s = miss_valid & ~hold_active_s;
  end

  // Round-robin pick: scan from rr_ptr upward (wrapping), first eligible wins.
  always_comb begin
    found_s  = 1'b0;
    hit_s    = 1'b0;
    winner_s = '0;
    cand_s   = '0;
    for (int i = 0; i < NUM_BANKS; i++) begin
      cand_s   = {1'b0, rr_ptr_r} + CNT_W'(i);
      cand_s   = (cand_s >= BANK_CNT) ? (cand_s - BANK_CNT) : cand_s;
      hit_s    = !found_s && eligible_s[cand_s[BANK_W-1:0]];
      winner_s = hit_s ? cand_s[BANK_W-1:0] : winner_s;
      found_s  = found_s | hit_s;
    end
  end

  // Winner's VPN (AND-OR mux) and the pointer value just past the winner.
  always_comb begin
    winner_vpn_s = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      winner_vpn_s = winner_vpn_s |
        ((winner_s == BANK_W'(b)) ? miss_vpn[b*VPN_WIDTH +: VPN_WIDTH] : '0);
    end
    inc_s     = {1'b0, winner_s} + CNT_W'(1);
    rr_next_s = (inc_s >= BANK_CNT) ? '0 : inc_s[BANK_W-1:0];
  end

  // Handshake fires; the grant is suppressed while reset is held.
  always_comb begin
    miss_ready_s = (state_r == IDLE && found_s && !reset) ? (BANK_ONE << winner_s) : '0;
    fire_s       = |miss_ready_s;
    req_fire_s   = (state_r == REQ) && ptw_req_ready;
    rsp_fire_s   = (state_r == RSP) && ptw_rsp_valid;
    upd_fire_s   = (state_r == UPD) && upd_ready[bank_r];
    done_s       = upd_fire_s || (state_r == FLT);
    bank_next_s  = fire_s ? winner_s : bank_r;
  end

  // Next-state logic of the walk FSM.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: state_next_s = fire_s ? REQ : IDLE;
      REQ:  state_next_s = ptw_req_ready ? RSP : REQ;
      RSP: begin
        if (ptw_rsp_valid) begin
          state_next_s = ptw_rsp_fault ? FLT : UPD;
        end else begin
          state_next_s = RSP;
        end
      end
      UPD:  state_next_s = upd_fire_s ? IDLE : UPD;
      FLT:  state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // FSM state, latched walk context and round-robin pointer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r  <= IDLE;
      rr_ptr_r <= '0;
      bank_r   <= '0;
      vpn_r    <= '0;
      ppn_r    <= '0;
    end else begin
      state_r <= state_next_s;
      if (fire_s) begin
        rr_ptr_r <= rr_next_s;
        bank_r   <= winner_s;
        vpn_r    <= winner_vpn_s;
      end else begin
        rr_ptr_r <= rr_ptr_r;
        bank_r   <= bank_r;
        vpn_r    <= vpn_r;
      end
      ppn_r <= (rsp_fire_s && !ptw_rsp_fault) ? ptw_rsp_ppn : ppn_r;
    end
  end

  // Per-state strobes registered from the next state so outputs are flop-driven.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_valid_r   <= 1'b0;
      rsp_ready_r   <= 1'b0;
      fault_valid_r <= 1'b0;
      upd_valid_r   <= '0;
    end else begin
      req_valid_r   <= (state_next_s == REQ);
      rsp_ready_r   <= (state_next_s == RSP);
      fault_valid_r <= (state_next_s == FLT);
      upd_valid_r   <= (state_next_s == UPD) ? (BANK_ONE << bank_next_s) : '0;
    end
  end

  // Holdoff down-counters, reloaded when the bank's update or fault completes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        holdoff_r[b] <= '0;
      end
    end else begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        if (done_s && bank_r == BANK_W'(b)) begin
          holdoff_r[b] <= HOLD_LOAD;
        end else if (holdoff_r[b] != '0) begin
          holdoff_r[b] <= holdoff_r[b] - HOLD_W'(1);
        end else begin
          holdoff_r[b] <= holdoff_r[b];
        end
      end
    end
  end

`ifdef VX_TLB_ARB_PERF_EN
  // Saturating walk and stall counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_walks  <= 32'd0;
      perf_stalls <= 32'd0;
    end else begin
      perf_walks  <= (req_fire_s && perf_walks != 32'hFFFF_FFFF) ?
                     perf_walks + 32'd1 : perf_walks;
      perf_stalls <= ((|miss_valid) && !fire_s && perf_stalls != 32'hFFFF_FFFF) ?
                     perf_stalls + 32'd1 : perf_stalls;
    end
  end
`endif

  assign miss_ready    = miss_ready_s;
  assign ptw_req_valid = req_valid_r;
  assign ptw_req_vpn   = vpn_r;
  assign ptw_rsp_ready = rsp_ready_r;
  assign upd_valid     = upd_valid_r;
  assign upd_vpn       = vpn_r;
  assign upd_ppn       = ppn_r;
  assign fault_valid   = fault_valid_r;
  assign fault_vpn     = vpn_r;
  assign fault_bank    = bank_r;

endmodule

// File: tb/tb_vx_tlb_miss_arb.sv
// Testbench for vx_tlb_miss_arb: directed scenarios, a transaction-level
// reference model checked every cycle, and literal expectations per scenario.
module tb_vx_tlb_miss_arb;
  localparam int NB = 4;
  localparam int VW = 20;
  localparam int HO = 2;
  localparam int BW = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic [NB-1:0]     miss_valid;
  logic [NB*VW-1:0]  miss_vpn;
  logic [NB-1:0]     miss_ready;
  logic              ptw_req_valid;
  logic [VW-1:0]     ptw_req_vpn;
  logic              ptw_req_ready;
  logic              ptw_rsp_valid;
  logic [VW-1:0]     ptw_rsp_ppn;
  logic              ptw_rsp_fault;
  logic              ptw_rsp_ready;
  logic [NB-1:0]     upd_valid;
  logic [VW-1:0]     upd_vpn;
  logic [VW-1:0]     upd_ppn;
  logic [NB-1:0]     upd_ready;
  logic              fault_valid;
  logic [VW-1:0]     fault_vpn;
  logic [BW-1:0]     fault_bank;
`ifdef VX_TLB_ARB_PERF_EN
  logic [31:0]       perf_walks;
  logic [31:0]       perf_stalls;
`endif

  vx_tlb_miss_arb #(.NUM_BANKS(NB), .VPN_WIDTH(VW), .HOLDOFF(HO)) dut (
    .clk(clk), .reset(reset),
    .miss_valid(miss_valid), .miss_vpn(miss_vpn), .miss_ready(miss_ready),
    .ptw_req_valid(ptw_req_valid), .ptw_req_vpn(ptw_req_vpn), .ptw_req_ready(ptw_req_ready),
    .ptw_rsp_valid(ptw_rsp_valid), .ptw_rsp_ppn(ptw_rsp_ppn), .ptw_rsp_fault(ptw_rsp_fault),
    .ptw_rsp_ready(ptw_rsp_ready),
    .upd_valid(upd_valid), .upd_vpn(upd_vpn), .upd_ppn(upd_ppn), .upd_ready(upd_ready),
    .fault_valid(fault_valid), .fault_vpn(fault_vpn), .fault_bank(fault_bank)
`ifdef VX_TLB_ARB_PERF_EN
    , .perf_walks(perf_walks), .perf_stalls(perf_stalls)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (walk-level view) ----------------
  int            cyc = 0;
  bit            m_busy = 1'b0;
  int            m_bank = 0;
  int            m_phase = 0;        // 0 request, 1 await result, 2 update, 3 fault
  logic [VW-1:0] m_vpn = '0;
  logic [VW-1:0] m_ppn = '0;
  int            ready_at [NB];      // first cycle a bank may be granted again
  int            m_rr = 0;
  int            m_walks = 0;
  int            m_stalls = 0;

  // ---------------- observation logs for literal checks ----------------
  int            grant_q[$];
  int            grant_cyc_q[$];
  int            upd_cyc_q[$];
  logic [NB-1:0] upd_mask_q[$];
  logic [VW-1:0] upd_vpn_q[$];
  logic [VW-1:0] upd_ppn_q[$];
  int            fault_cnt = 0;
  int            fault_cyc = 0;
  logic [VW-1:0] last_fault_vpn = '0;
  int            last_fault_bank = -1;
  logic [VW-1:0] first_req_vpn = '0;
  bit            first_req_seen = 1'b0;
  int            req_beef_cycles = 0;
  int            upd3_cycles = 0;

  task automatic clear_logs();
    grant_q.delete(); grant_cyc_q.delete(); upd_cyc_q.delete();
    upd_mask_q.delete(); upd_vpn_q.delete(); upd_ppn_q.delete();
    fault_cnt = 0; last_fault_bank = -1; last_fault_vpn = '0;
    first_req_seen = 1'b0; first_req_vpn = '0;
    req_beef_cycles = 0; upd3_cycles = 0;
  endtask

  // Compare process: outputs are sampled on the falling edge.
  always @(negedge clk) begin : compare
    int win, idx;
    logic [NB-1:0] e_mr, e_upd;
    logic e_req, e_rsp, e_flt;
    cyc++;
    check("no_x", 128'($isunknown({miss_ready, ptw_req_valid, ptw_req_vpn, ptw_rsp_ready,
          upd_valid, upd_vpn, upd_ppn, fault_valid, fault_vpn, fault_bank})), 128'd0);
    if (reset) begin
      check("rst_ctrl", {miss_ready, ptw_req_valid, ptw_rsp_ready, upd_valid, fault_valid}, 128'd0);
      check("rst_data", {ptw_req_vpn, upd_vpn, upd_ppn, fault_vpn, fault_bank}, 128'd0);
      m_busy = 1'b0; m_rr = 0; m_walks = 0; m_stalls = 0;
      for (int b = 0; b < NB; b++) ready_at[b] = 0;
    end else begin
      win = -1;
      if (!m_busy) begin
        for (int k = 0; k < NB; k++) begin
          idx = (m_rr + k) % NB;
          if (win < 0 && miss_valid[idx] && cyc >= ready_at[idx]) win = idx;
        end
      end
      e_mr  = (win >= 0) ? (NB'(1) << win) : '0;
      e_req = m_busy && m_phase == 0;
      e_rsp = m_busy && m_phase == 1;
      e_upd = (m_busy && m_phase == 2) ? (NB'(1) << m_bank) : '0;
      e_flt = m_busy && m_phase == 3;
      check("miss_ready", miss_ready, e_mr);
      check("ptw_req_valid", ptw_req_valid, e_req);
      check("ptw_rsp_ready", ptw_rsp_ready, e_rsp);
      check("upd_valid", upd_valid, e_upd);
      check("fault_valid", fault_valid, e_flt);
      if (e_req) check("ptw_req_vpn", ptw_req_vpn, m_vpn);
      if (e_upd != 0) check("upd_data", {upd_vpn, upd_ppn}, {m_vpn, m_ppn});
      if (e_flt) check("fault_data", {fault_vpn, fault_bank}, {m_vpn, BW'(m_bank)});
`ifdef VX_TLB_ARB_PERF_EN
      check("perf", {perf_walks, perf_stalls}, {32'(m_walks), 32'(m_stalls)});
`endif
      // advance the model across the coming rising edge
      if (|miss_valid && win < 0) m_stalls++;
      if (m_busy) begin
        case (m_phase)
          0: if (ptw_req_ready) begin m_phase = 1; m_walks++; end
          1: if (ptw_rsp_valid) begin
               if (ptw_rsp_fault) m_phase = 3;
               else begin m_phase = 2; m_ppn = ptw_rsp_ppn; end
             end
          2: if (upd_ready[m_bank]) begin m_busy = 1'b0; ready_at[m_bank] = cyc + HO + 1; end
          default: begin m_busy = 1'b0; ready_at[m_bank] = cyc + HO + 1; end
        endcase
      end else if (win >= 0) begin
        m_busy = 1'b1; m_bank = win; m_phase = 0;
        m_vpn = miss_vpn[win*VW +: VW];
        m_rr = (win + 1) % NB;
      end
    end
    // observation logs
    for (int b = 0; b < NB; b++) begin
      if (miss_ready[b]) begin grant_q.push_back(b); grant_cyc_q.push_back(cyc); end
    end
    if ((upd_valid & upd_ready) != 0) begin
      upd_cyc_q.push_back(cyc); upd_mask_q.push_back(upd_valid);
      upd_vpn_q.push_back(upd_vpn); upd_ppn_q.push_back(upd_ppn);
    end
    if (fault_valid) begin
      fault_cnt++; fault_cyc = cyc; last_fault_vpn = fault_vpn; last_fault_bank = int'(fault_bank);
    end
    if (ptw_req_valid && !first_req_seen) begin first_req_seen = 1'b1; first_req_vpn = ptw_req_vpn; end
    if (ptw_req_valid && ptw_req_vpn == 20'h0BEEF) req_beef_cycles++;
    if (upd_valid == 4'b1000) upd3_cycles++;
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle_inputs();
    miss_valid = '0; ptw_req_ready = 1'b0; ptw_rsp_valid = 1'b0;
    ptw_rsp_ppn = '0; ptw_rsp_fault = 1'b0; upd_ready = '0;
  endtask

  task automatic set_vpn(input int b, input logic [VW-1:0] v);
    miss_vpn[b*VW +: VW] = v;
  endtask

  task automatic do_reset();
    reset = 1'b1; tick(); tick(); reset = 1'b0;
  endtask

  task automatic drain();
    miss_valid = '0; ptw_req_ready = 1'b1; ptw_rsp_valid = 1'b1;
    ptw_rsp_fault = 1'b0; upd_ready = '1;
    repeat (8) tick();
    idle_inputs();
  endtask

  // Wait (bounded) for ptw_rsp_ready (sel 0) or any upd_valid (sel 1).
  task automatic wait_for(input int sel, input int limit, input string name);
    bit seen = 1'b0;
    for (int i = 0; i < limit && !seen; i++) begin
      @(negedge clk);
      seen = (sel == 0) ? ptw_rsp_ready : |upd_valid;
    end
    check(name, 128'(seen), 128'd1);
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    reset = 1'b1;
    miss_vpn = '0;
    idle_inputs();
    for (int b = 0; b < NB; b++) ready_at[b] = 0;
    repeat (3) tick();
    reset = 1'b0;
    tick();

    // --- single miss from bank 2, PTW answers 3 cycles late ---
    clear_logs();
    set_vpn(0, 20'h00001); set_vpn(1, 20'h00002); set_vpn(2, 20'h12345); set_vpn(3, 20'h00004);
    miss_valid = 4'b0100; ptw_req_ready = 1'b1; upd_ready = 4'hF;
    wait_for(0, 10, "t1_wait_rsp");
    repeat (3) tick();
    ptw_rsp_valid = 1'b1; ptw_rsp_ppn = 20'h00ABC;
    tick();
    ptw_rsp_valid = 1'b0;
    repeat (6) tick();
    check("t1_first_req_vpn", first_req_vpn, 20'h12345);
    check("t1_grant0", (grant_q.size() > 0) ? grant_q[0] : -1, 2);
    check("t1_upd_mask", (upd_mask_q.size() > 0) ? upd_mask_q[0] : 4'b0, 4'b0100);
    check("t1_upd_ppn", (upd_ppn_q.size() > 0) ? upd_ppn_q[0] : 20'h0, 20'h00ABC);
    check("t1_grant1", (grant_q.size() > 1) ? grant_q[1] : -1, 2);
    check("t1_regrant_gap",
          (grant_cyc_q.size() > 1 && upd_cyc_q.size() > 0) ? grant_cyc_q[1] - upd_cyc_q[0] : -1, 3);
    drain();

    // --- all four banks at once from a fresh reset, zero-wait PTW ---
    do_reset();
    clear_logs();
    for (int b = 0; b < NB; b++) set_vpn(b, 20'h00100 + 20'(b));
    miss_valid = 4'hF; ptw_req_ready = 1'b1; ptw_rsp_valid = 1'b1;
    ptw_rsp_ppn = 20'h00777; upd_ready = 4'hF;
    repeat (14) tick();
    miss_valid = '0;
    drain();
    check("t2_grant_count", grant_q.size(), 4);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("t2_grant%0d", k), (grant_q.size() > k) ? grant_q[k] : -1, k);
      check($sformatf("t2_upd%0d", k), (upd_mask_q.size() > k) ? upd_mask_q[k] : 4'b0, 4'b0001 << k);
    end
    check("t2_spacing", (grant_cyc_q.size() > 3) ? grant_cyc_q[3] - grant_cyc_q[0] : -1, 12);
    check("t2_upd3_vpn", (upd_vpn_q.size() > 3) ? upd_vpn_q[3] : 20'h0, 20'h00103);

    // --- fault from bank 1 ---
    clear_logs();
    set_vpn(1, 20'h00042);
    miss_valid = 4'b0010; ptw_req_ready = 1'b1; ptw_rsp_valid = 1'b1;
    ptw_rsp_fault = 1'b1; upd_ready = 4'hF;
    tick();
    miss_valid = '0;
    repeat (6) tick();
    idle_inputs();
    check("t3_fault_cnt", fault_cnt, 1);
    check("t3_fault_vpn", last_fault_vpn, 20'h00042);
    check("t3_fault_bank", last_fault_bank, 1);
    check("t3_no_upd", upd_cyc_q.size(), 0);
    check("t3_latency", (grant_cyc_q.size() > 0) ? fault_cyc - grant_cyc_q[0] : -1, 3);

    // --- backpressure: request stalls 5 cycles, bank 3 update stalls 4 ---
    clear_logs();
    set_vpn(3, 20'h0BEEF); set_vpn(0, 20'h00DAD);
    miss_valid = 4'b1001; ptw_req_ready = 1'b0; ptw_rsp_valid = 1'b1;
    ptw_rsp_ppn = 20'h0CAFE; upd_ready = 4'b0111;
    tick();
    repeat (5) tick();
    ptw_req_ready = 1'b1;
    wait_for(1, 10, "t4_wait_upd");
    repeat (4) tick();
    upd_ready = 4'hF;
    repeat (2) tick();
    drain();
    check("t4_req_cycles", req_beef_cycles, 6);
    check("t4_upd_cycles", upd3_cycles, 5);
    check("t4_grant_count", grant_q.size(), 2);
    check("t4_grant0", (grant_q.size() > 0) ? grant_q[0] : -1, 3);
    check("t4_grant1", (grant_q.size() > 1) ? grant_q[1] : -1, 0);

    // --- reset while waiting for the walk result ---
    set_vpn(2, 20'h00555);
    miss_valid = 4'b0100; ptw_req_ready = 1'b1; upd_ready = 4'hF;
    tick();
    miss_valid = '0;
    wait_for(0, 10, "t5_wait_rsp");
    tick();
    reset = 1'b1; ptw_rsp_valid = 1'b1; ptw_rsp_ppn = 20'h00666;
    #1;
    check("t5_async_ctrl", {miss_ready, ptw_req_valid, ptw_rsp_ready, upd_valid, fault_valid}, 128'd0);
    check("t5_async_data", {ptw_req_vpn, upd_vpn, upd_ppn, fault_vpn, fault_bank}, 128'd0);
    tick(); tick();
    reset = 1'b0;
    tick();
    clear_logs();
    set_vpn(1, 20'h00011); set_vpn(3, 20'h00033);
    ptw_rsp_valid = 1'b0; miss_valid = 4'b1010;
    tick();
    miss_valid = '0;
    drain();
    check("t5_grant0", (grant_q.size() > 0) ? grant_q[0] : -1, 1);
    check("t5_upd_count", upd_cyc_q.size(), 1);
    check("t5_upd_mask", (upd_mask_q.size() > 0) ? upd_mask_q[0] : 4'b0, 4'b0010);

    repeat (2) tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
